// File: rtl/weight_sparse_enc_par_if.sv
// -----------------------------------------------------------------------------
// weight_sparse_enc_par_if
// Valid/ready weight stream bundle for weight_sparse_enc_par.
//   in_valid  : producer has a beat on data_in
//   in_ready  : encoder can take the beat
//   data_in   : LANES x DATA_W weights, lane l at [l*DATA_W +: DATA_W]
//   out_valid : encoder has a beat on data_out
//   out_ready : downstream takes the beat
//   data_out  : LANES x (DATA_W+1), lane l = {zero flag, weight}
// Modports: slave = encoder view, master = producer/consumer (bench) view.
// -----------------------------------------------------------------------------
interface weight_sparse_enc_par_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic [LANES*DATA_W-1:0]      data_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES*(DATA_W+1)-1:0]  data_out;

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );
endinterface

// File: rtl/weight_sparse_enc_par.sv
// -----------------------------------------------------------------------------
// weight_sparse_enc_par
// Multi-lane weight sparsity encoder. Registers LANES weights per accepted beat,
// flags zero weights per lane and builds a COL_DEPTH-bit sparsity bitmap per
// lane over a weight column. A closed column (full, or flushed early with the
// unfilled positions padded as zero) is published on sparse_map with a one
// enabled-cycle sp_col pulse and, optionally, a per-lane zero count.
//
// Optional build macro: WSE_ZERO_CNT_EN
//   defined   : col_zero_cnt carries the per-lane popcount of the closed map
//   undefined : no popcount logic, col_zero_cnt tied to 0
//
// Ports:
//   sys_clk      : clock, rising edge
//   rst          : asynchronous active-high reset
//   sys_en       : global enable, 0 freezes every register
//   bus          : valid/ready weight stream (slave modport)
//   col_flush    : close the current column early (pulse)
//   sp_out       : per-lane zero flag of the registered weight
//   sparse_map   : last closed column bitmap, bit l*COL_DEPTH+k = lane l elem k zero
//   col_zero_cnt : per-lane zero count of the last closed column
//   sp_col       : pulse, sparse_map/col_zero_cnt just updated
//   col_idx      : index of the next element in the current column
// -----------------------------------------------------------------------------
module weight_sparse_enc_par #(
    parameter int DATA_W    = 8,
    parameter int LANES     = 4,
    parameter int COL_DEPTH = 8,
    parameter int CNT_W     = $clog2(COL_DEPTH+1)
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          sys_en,
    weight_sparse_enc_par_if.slave        bus,
    input  logic                          col_flush,
    output logic [LANES-1:0]              sp_out,
    output logic [LANES*COL_DEPTH-1:0]    sparse_map,
    output logic [LANES*CNT_W-1:0]        col_zero_cnt,
    output logic                          sp_col,
    output logic [$clog2(COL_DEPTH)-1:0]  col_idx
);
    localparam int IDX_W  = $clog2(COL_DEPTH);
    localparam int FILL_W = IDX_W + 1;

    logic [LANES*DATA_W-1:0]      data_r;
    logic                         out_valid_r;
    logic [LANES*COL_DEPTH-1:0]   work_map_r;
    logic [LANES*COL_DEPTH-1:0]   sparse_map_r;
    logic                         sp_col_r;
    logic [IDX_W-1:0]             col_idx_r;

    logic                         in_ready_s;
    logic                         accept_s;
    logic                         last_elem_s;
    logic                         close_s;
    logic [LANES-1:0]             in_zero_s;
    logic [LANES-1:0]             sp_out_s;
    logic [LANES*(DATA_W+1)-1:0]  data_out_s;
    logic [LANES*COL_DEPTH-1:0]   work_next_s;
    logic [LANES*COL_DEPTH-1:0]   close_map_s;
    logic [FILL_W-1:0]            filled_s;

    // Reset is gated in so no beat is taken while the block is held in reset.
    assign in_ready_s  = sys_en & ~rst & (~out_valid_r | bus.out_ready);
    assign accept_s    = bus.in_valid & in_ready_s;
    assign last_elem_s = (col_idx_r == IDX_W'(COL_DEPTH-1));
    // A flush on an empty column with no incoming beat has nothing to close.
    assign close_s     = (accept_s & last_elem_s) |
                         (sys_en & col_flush & ((col_idx_r != {IDX_W{1'b0}}) | accept_s));

    // Zero flags of incoming and registered weights, and the output lane packing.
    always_comb begin
        in_zero_s  = {LANES{1'b0}};
        sp_out_s   = {LANES{1'b0}};
        data_out_s = {(LANES*(DATA_W+1)){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            in_zero_s[l] = (bus.data_in[l*DATA_W +: DATA_W] == {DATA_W{1'b0}});
            sp_out_s[l]  = (data_r[l*DATA_W +: DATA_W] == {DATA_W{1'b0}});
            data_out_s[l*(DATA_W+1) +: (DATA_W+1)] = {sp_out_s[l], data_r[l*DATA_W +: DATA_W]};
        end
    end

    // Working map including this cycle's bit, and the padded map used at close.
    always_comb begin
        work_next_s = work_map_r;
        close_map_s = {(LANES*COL_DEPTH){1'b0}};
        if (accept_s) begin
            for (int l = 0; l < LANES; l++) begin
                work_next_s[l*COL_DEPTH + int'(col_idx_r)] = in_zero_s[l];
            end
        end else begin
            work_next_s = work_map_r;
        end
        // Number of positions holding real data once this cycle's beat lands.
        filled_s = {1'b0, col_idx_r} + {{IDX_W{1'b0}}, accept_s};
        // Unfilled positions of an early-closed column count as zero weights.
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < COL_DEPTH; k++) begin
                if (FILL_W'(k) >= filled_s) begin
                    close_map_s[l*COL_DEPTH + k] = 1'b1;
                end else begin
                    close_map_s[l*COL_DEPTH + k] = work_next_s[l*COL_DEPTH + k];
                end
            end
        end
    end

    // Data path, handshake, column accumulation and column close.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            data_r       <= {(LANES*DATA_W){1'b0}};
            out_valid_r  <= 1'b0;
            work_map_r   <= {(LANES*COL_DEPTH){1'b0}};
            sparse_map_r <= {(LANES*COL_DEPTH){1'b0}};
            sp_col_r     <= 1'b0;
            col_idx_r    <= {IDX_W{1'b0}};
        end else if (sys_en) begin
            if (accept_s) begin
                data_r      <= bus.data_in;
                out_valid_r <= 1'b1;
            end else if (out_valid_r & bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
            sp_col_r <= close_s;
            if (close_s) begin
                sparse_map_r <= close_map_s;
                work_map_r   <= {(LANES*COL_DEPTH){1'b0}};
                col_idx_r    <= {IDX_W{1'b0}};
            end else if (accept_s) begin
                work_map_r   <= work_next_s;
                col_idx_r    <= col_idx_r + IDX_W'(1'b1);
            end
        end
    end

`ifdef WSE_ZERO_CNT_EN
    logic [LANES*CNT_W-1:0] close_cnt_s;
    logic [LANES*CNT_W-1:0] zero_cnt_r;

    function automatic logic [CNT_W-1:0] popcount(input logic [COL_DEPTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int k = 0; k < COL_DEPTH; k++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[k]};
        end
        return c;
    endfunction

    // Per-lane zero count of the map being closed.
    always_comb begin
        close_cnt_s = {(LANES*CNT_W){1'b0}};
        for (int l = 0; l < LANES; l++) begin
            close_cnt_s[l*CNT_W +: CNT_W] = popcount(close_map_s[l*COL_DEPTH +: COL_DEPTH]);
        end
    end

    // Zero count register, updated together with sparse_map.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            zero_cnt_r <= {(LANES*CNT_W){1'b0}};
        end else if (sys_en & close_s) begin
            zero_cnt_r <= close_cnt_s;
        end
    end

    assign col_zero_cnt = zero_cnt_r;
`else
    assign col_zero_cnt = {(LANES*CNT_W){1'b0}};
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.data_out  = data_out_s;
    assign sp_out        = sp_out_s;
    assign sparse_map    = sparse_map_r;
    assign sp_col        = sp_col_r;
    assign col_idx       = col_idx_r;
endmodule

// File: tb/tb_weight_sparse_enc_par.sv
// -----------------------------------------------------------------------------
// tb_weight_sparse_enc_par
// Directed and randomized stimulus for weight_sparse_enc_par, checked every
// cycle against a queue-based reference model of the column encoder.
// -----------------------------------------------------------------------------
module tb_weight_sparse_enc_par;
    localparam int DATA_W    = 8;
    localparam int LANES     = 4;
    localparam int COL_DEPTH = 8;
    localparam int CNT_W     = $clog2(COL_DEPTH+1);
    localparam int IDX_W     = $clog2(COL_DEPTH);
`ifdef WSE_ZERO_CNT_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic rst;
    logic sys_en;
    logic col_flush;
    logic [LANES-1:0]             sp_out;
    logic [LANES*COL_DEPTH-1:0]   sparse_map;
    logic [LANES*CNT_W-1:0]       col_zero_cnt;
    logic                         sp_col;
    logic [IDX_W-1:0]             col_idx;

    weight_sparse_enc_par_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();

    weight_sparse_enc_par #(
        .DATA_W(DATA_W), .LANES(LANES), .COL_DEPTH(COL_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .sys_en      (sys_en),
        .bus         (bus),
        .col_flush   (col_flush),
        .sp_out      (sp_out),
        .sparse_map  (sparse_map),
        .col_zero_cnt(col_zero_cnt),
        .sp_col      (sp_col),
        .col_idx     (col_idx)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state
    logic                  m_ov;
    logic [DATA_W-1:0]     m_w   [LANES];
    logic [LANES-1:0]      col_q [$];
    logic [COL_DEPTH-1:0]  m_map [LANES];
    int                    m_cnt [LANES];
    logic                  m_sp;

    int n_vec = 0;
    int n_bad = 0;
    int sp_pulses;
    logic [63:0] held;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ov = 1'b0;
        col_q.delete();
        m_sp = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            m_w[l]   = '0;
            m_map[l] = '0;
            m_cnt[l] = 0;
        end
    endtask

    // One enabled or frozen clock edge of the encoder, from the column rules.
    task automatic model_step(input bit en, input bit v, input logic [31:0] d,
                              input bit fl, input bit ordy);
        bit acc;
        bit close;
        bit b;
        logic [LANES-1:0] zf;
        if (en) begin
            acc = v && (!m_ov || ordy);
            if (acc) begin
                for (int l = 0; l < LANES; l++) begin
                    m_w[l] = d[l*DATA_W +: DATA_W];
                    zf[l]  = (m_w[l] == 0);
                end
                col_q.push_back(zf);
            end
            close = (col_q.size() == COL_DEPTH) || (fl && col_q.size() != 0);
            if (close) begin
                for (int l = 0; l < LANES; l++) begin
                    m_cnt[l] = 0;
                    for (int k = 0; k < COL_DEPTH; k++) begin
                        b = (k < col_q.size()) ? col_q[k][l] : 1'b1;
                        m_map[l][k] = b;
                        m_cnt[l] += int'(b);
                    end
                end
                col_q.delete();
            end
            m_sp = close;
            if (acc) m_ov = 1'b1;
            else if (m_ov && ordy) m_ov = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [63:0] e_do, e_map, e_cnt, e_sp;
        e_do = '0; e_map = '0; e_cnt = '0; e_sp = '0;
        for (int l = 0; l < LANES; l++) begin
            e_do[l*(DATA_W+1) +: (DATA_W+1)] = {(m_w[l] == 0), m_w[l]};
            e_sp[l] = (m_w[l] == 0);
            e_map[l*COL_DEPTH +: COL_DEPTH] = m_map[l];
            e_cnt[l*CNT_W +: CNT_W] = ZC ? CNT_W'(m_cnt[l]) : '0;
        end
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("data_out", 64'(bus.data_out), e_do);
        chk("sp_out", 64'(sp_out), e_sp);
        chk("sparse_map", 64'(sparse_map), e_map);
        chk("col_zero_cnt", 64'(col_zero_cnt), e_cnt);
        chk("sp_col", 64'(sp_col), 64'(m_sp));
        chk("col_idx", 64'(col_idx), 64'(col_q.size()));
    endtask

    task automatic cycle(input bit en, input bit v, input logic [31:0] d,
                         input bit fl, input bit ordy);
        @(negedge sys_clk);
        sys_en = en; bus.in_valid = v; bus.data_in = d;
        col_flush = fl; bus.out_ready = ordy;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(en && (!m_ov || ordy)));
        @(posedge sys_clk);
        model_step(en, v, d, fl, ordy);
        #1;
        check_outputs();
        if (sp_col) sp_pulses++;
    endtask

    function automatic logic [31:0] nz4();
        logic [31:0] d;
        for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = 8'($urandom_range(1, 255));
        return d;
    endfunction

    function automatic logic [31:0] sparse4();
        logic [31:0] d;
        for (int l = 0; l < LANES; l++)
            d[l*DATA_W +: DATA_W] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        return d;
    endfunction

    initial begin
        logic [7:0] lane0_seq [8];
        logic [31:0] d;
        lane0_seq = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd1, 8'd0};

        rst = 1'b1; sys_en = 1'b0; col_flush = 1'b0;
        bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge sys_clk);
        #1;
        check_outputs();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge sys_clk);
        rst = 1'b0;

        // Full column: lane0 pattern, lanes 1-3 nonzero
        for (int i = 0; i < 8; i++) cycle(1, 1, {8'h11, 8'h11, 8'h11, lane0_seq[i]}, 0, 1);
        chk("tp1_map_lane0", 64'(sparse_map[7:0]), 64'hAD);
        chk("tp1_map_others", 64'(sparse_map[31:8]), 64'h0);
        chk("tp1_cnt", 64'(col_zero_cnt), ZC ? 64'h0005 : 64'h0);
        chk("tp1_sp_col", 64'(sp_col), 64'd1);
        cycle(1, 0, 32'h0, 0, 1);

        // Backpressure: data_out must hold while out_ready is low
        cycle(1, 1, sparse4(), 0, 0);
        held = 64'(bus.data_out);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, $urandom, 0, 0);
            chk("bp_stable", 64'(bus.data_out), held);
        end
        cycle(1, 0, 32'h0, 0, 1);
        cycle(1, 1, sparse4(), 0, 1);
        cycle(1, 0, 32'h0, 1, 1);

        // Early flush after 3 nonzero beats
        for (int i = 0; i < 3; i++) cycle(1, 1, nz4(), 0, 1);
        cycle(1, 0, 32'h0, 1, 1);
        chk("flush3_map", 64'(sparse_map), 64'hF8F8F8F8);
        chk("flush3_cnt", 64'(col_zero_cnt), ZC ? 64'h5555 : 64'h0);
        chk("flush3_idx", 64'(col_idx), 64'd0);

        // Flush together with an accept at col_idx 2, lane1 zero
        for (int i = 0; i < 2; i++) cycle(1, 1, nz4(), 0, 1);
        d = nz4(); d[15:8] = 8'h00;
        cycle(1, 1, d, 1, 1);
        chk("flushacc_map", 64'(sparse_map), 64'hF8F8FCF8);
        chk("flushacc_sp", 64'(sp_col), 64'd1);

        // Flush on an empty column is a no-op
        cycle(1, 0, 32'h0, 1, 1);
        chk("flush0_sp", 64'(sp_col), 64'd0);
        chk("flush0_map", 64'(sparse_map), 64'hF8F8FCF8);

        // sys_en dropped on the sp_col cycle keeps the pulse pending
        for (int i = 0; i < 8; i++) cycle(1, 1, sparse4(), 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, $urandom, 1, 1);
            chk("freeze_sp", 64'(sp_col), 64'd1);
        end
        cycle(1, 0, 32'h0, 0, 1);

        // Reset mid-column discards the partial column
        for (int i = 0; i < 4; i++) cycle(1, 1, sparse4(), 0, 1);
        @(negedge sys_clk);
        sys_en = 1'b1; bus.in_valid = 1'b0; col_flush = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_mid_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge sys_clk);
        rst = 1'b0;
        sp_pulses = 0;
        for (int i = 0; i < 8; i++) cycle(1, 1, sparse4(), 0, 1);
        for (int i = 0; i < 2; i++) cycle(1, 0, 32'h0, 0, 1);
        chk("rst_fresh_pulses", 64'(sp_pulses), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, sparse4(),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
